// File: rtl/ram_pkg.sv
// Shared constants and types for the dual-port RAM with clear sequencer.
package ram_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, one word per cycle,
// then parks in READY with the counter held at the last address.
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int addr_width_g     = 11,
   parameter int clear_on_reset_g = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    clr_we,
   output logic [addr_width_g-1:0] clr_addr,
   output logic                    busy
);

   clr_state_t              state_q, state_d;
   logic [addr_width_g-1:0] cnt_q, cnt_d;

   // State and sweep counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= (clear_on_reset_g != 0) ? CLEAR : READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: leave CLEAR once the all-ones address has been written
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (cnt_q == {addr_width_g{1'b1}}) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + {{(addr_width_g-1){1'b0}}, 1'b1};
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = READY;
         end
      endcase
   end

   // Outputs decoded from the state register
   always_comb begin
      clr_addr = cnt_q;
      case (state_q)
         CLEAR: begin
            clr_we = 1'b1;
            busy   = 1'b1;
         end
         READY: begin
            clr_we = 1'b0;
            busy   = 1'b0;
         end
         default: begin
            clr_we = 1'b0;
            busy   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ram_dp_clr.sv
// True dual-port synchronous RAM. Port A's write path is shared with the clear
// sweep; port B loses same-address write collisions to port A.
module ram_dp_clr
   import ram_pkg::*;
#(
   parameter int                      addr_width_g     = 11,
   parameter int                      data_width_g     = 8,
   parameter int                      rdw_mode_g       = 0,
   parameter int                      clear_on_reset_g = 1,
   parameter logic [data_width_g-1:0] clear_value_g    = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [addr_width_g-1:0] address_a,
   input  logic [data_width_g-1:0] data_a,
   input  logic                    wren_a,
   output logic [data_width_g-1:0] q_a,
   input  logic [addr_width_g-1:0] address_b,
   input  logic [data_width_g-1:0] data_b,
   input  logic                    wren_b,
   output logic [data_width_g-1:0] q_b,
   output logic                    busy
);

   localparam int DEPTH = 2 ** addr_width_g;

   logic [data_width_g-1:0] mem_q [DEPTH];
   logic [data_width_g-1:0] q_a_q, q_a_d;
   logic [data_width_g-1:0] q_b_q, q_b_d;

   logic                    clr_we;
   logic [addr_width_g-1:0] clr_addr;
   logic                    we_a_s;
   logic [addr_width_g-1:0] wa_addr_s;
   logic [data_width_g-1:0] wa_data_s;
   logic                    we_b_s;

   ram_clear_seq #(
      .addr_width_g    (addr_width_g),
      .clear_on_reset_g(clear_on_reset_g)
   ) u_clear_seq (
      .clock   (clock),
      .reset   (reset),
      .clr_we  (clr_we),
      .clr_addr(clr_addr),
      .busy    (busy)
   );

   // Write-port selection: sweep owns port A while busy; nothing writes during reset
   always_comb begin
      we_a_s    = 1'b0;
      wa_addr_s = address_a;
      wa_data_s = data_a;
      we_b_s    = 1'b0;
      if (reset) begin
         we_a_s = 1'b0;
         we_b_s = 1'b0;
      end else if (busy) begin
         we_a_s    = clr_we;
         wa_addr_s = clr_addr;
         wa_data_s = clear_value_g;
      end else begin
         we_a_s = wren_a;
         we_b_s = wren_b && !(wren_a && (address_a == address_b));
      end
   end

   // Read data: held at zero while sweeping; optional write-through on own port
   always_comb begin
      q_a_d = '0;
      q_b_d = '0;
      if (busy) begin
         q_a_d = '0;
         q_b_d = '0;
      end else begin
         if ((rdw_mode_g == RDW_NEW) && wren_a) begin
            q_a_d = data_a;
         end else begin
            q_a_d = mem_q[address_a];
         end
         if ((rdw_mode_g == RDW_NEW) && we_b_s) begin
            q_b_d = data_b;
         end else begin
            q_b_d = mem_q[address_b];
         end
      end
   end

   // Storage array (not reset; the sweep initialises it)
   always_ff @(posedge clock) begin
      if (we_a_s) begin
         mem_q[wa_addr_s] <= wa_data_s;
      end
      if (we_b_s) begin
         mem_q[address_b] <= data_b;
      end
   end

   // Registered read outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         q_a_q <= '0;
         q_b_q <= '0;
      end else begin
         q_a_q <= q_a_d;
         q_b_q <= q_b_d;
      end
   end

   assign q_a = q_a_q;
   assign q_b = q_b_q;

endmodule
